// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Constants, types and helpers shared between the input loader and the
// NeuralNetwork core.
//   NUM_PIXELS      : words per flattened frame
//   DATA_WIDTH      : width of one NNin word (Q8.8)
//   DATA_FRAC_WIDTH : fractional bits of one NNin word
//   PIX_WIDTH       : width of an incoming unsigned pixel
//   pix_to_fixed    : pixel -> Q8.8 word, pixel lands in the fractional field
//   loader_state_t  : LOAD (collecting pixels) / HOLD (frame presented)
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int NUM_PIXELS      = 784;
    localparam int DATA_WIDTH      = 16;
    localparam int DATA_FRAC_WIDTH = 8;
    localparam int PIX_WIDTH       = 8;

    typedef logic [DATA_WIDTH-1:0] fixed_word_t;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

    // The pixel is zero-extended into the low fractional bits, giving
    // value = pix / 2**DATA_FRAC_WIDTH. No rounding, no sign extension.
    function automatic fixed_word_t pix_to_fixed(input logic [PIX_WIDTH-1:0] pix);
        fixed_word_t word;
        word                = '0;
        word[PIX_WIDTH-1:0] = pix;
        return word;
    endfunction

endpackage

// File: rtl/nn_input_loader.sv
// -----------------------------------------------------------------------------
// nn_input_loader
// Producer side of the NeuralNetwork input interface. Accepts 8-bit pixels
// over valid/ready, converts each to Q8.8, stores it into one slot of a
// flattened 784-word frame and presents the frame on NNin/NNvalid until the
// network signals completion on nnDone.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   pixIn     : unsigned pixel
//   pixValid  : pixIn valid
//   pixLast   : final pixel of a frame (qualified by pixValid)
//   pixReady  : loader accepts a pixel this cycle
//   nnDone    : completion from NeuralNetwork (maxValid)
//   NNin      : flattened frame, pixel i at NNin[i*DATA_WIDTH +: DATA_WIDTH]
//   NNvalid   : frame complete and stable (level)
//   frameErr  : one-cycle pulse on a short frame or a missing pixLast
//   pixCount  : pixels accepted so far in the current frame
// -----------------------------------------------------------------------------
module nn_input_loader
    import nn_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PIX_WIDTH-1:0]               pixIn,
    input  logic                               pixValid,
    input  logic                               pixLast,
    output logic                               pixReady,
    input  logic                               nnDone,
    output logic [NUM_PIXELS*DATA_WIDTH-1:0]   NNin,
    output logic                               NNvalid,
    output logic                               frameErr,
    output logic [9:0]                         pixCount
);

    localparam int IDX_W = $clog2(NUM_PIXELS*DATA_WIDTH);
    localparam logic [9:0] LAST_SLOT = 10'(NUM_PIXELS-1);

    loader_state_t                  state_q, state_d;
    logic                           pixready_q, pixready_d;
    logic                           nnvalid_q, nnvalid_d;
    logic                           frame_err_q, frame_err_d;
    logic [9:0]                     pixcount_q, pixcount_d;
    logic [NUM_PIXELS*DATA_WIDTH-1:0] nnin_q;

    logic                           accept_s;
    logic                           last_slot_s;
    logic                           wr_en_s;
    logic [IDX_W-1:0]               wr_base_s;
    fixed_word_t                    wr_data_s;

    assign accept_s    = pixValid & pixready_q;
    assign last_slot_s = (pixcount_q == LAST_SLOT);
    // Bit offset of the slot addressed by the current pixel count.
    assign wr_base_s   = IDX_W'(pixcount_q) * IDX_W'(DATA_WIDTH);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a full frame moves to HOLD, nnDone releases it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (accept_s && last_slot_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = LOAD;
                end
            end
            HOLD: begin
                if (nnDone) begin
                    state_d = LOAD;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Output/datapath decode; handshake flags follow the state being entered
    // so they change in the same cycle as the state itself.
    always_comb begin
        pixcount_d  = pixcount_q;
        frame_err_d = 1'b0;
        wr_en_s     = 1'b0;
        wr_data_s   = pix_to_fixed(pixIn);
        pixready_d  = (state_d == LOAD);
        nnvalid_d   = (state_d == HOLD);
        case (state_q)
            LOAD: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    if (last_slot_s) begin
                        // Frame full: overrun is flagged if pixLast is missing.
                        pixcount_d  = 10'd0;
                        frame_err_d = ~pixLast;
                    end else if (pixLast) begin
                        // Short frame: restart, keep partial data in NNin.
                        pixcount_d  = 10'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        pixcount_d  = pixcount_q + 10'd1;
                    end
                end else begin
                    pixcount_d = pixcount_q;
                end
            end
            HOLD: begin
                pixcount_d = 10'd0;
            end
            default: begin
                pixcount_d = 10'd0;
            end
        endcase
    end

    // Handshake, status and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pixready_q  <= 1'b0;
            nnvalid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            pixcount_q  <= 10'd0;
        end else begin
            pixready_q  <= pixready_d;
            nnvalid_q   <= nnvalid_d;
            frame_err_q <= frame_err_d;
            pixcount_q  <= pixcount_d;
        end
    end

    // Frame storage: single write port, one slot per accepted pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nnin_q <= '0;
        end else if (wr_en_s) begin
            nnin_q[wr_base_s +: DATA_WIDTH] <= wr_data_s;
        end else begin
            nnin_q <= nnin_q;
        end
    end

    assign pixReady = pixready_q;
    assign NNvalid  = nnvalid_q;
    assign frameErr = frame_err_q;
    assign pixCount = pixcount_q;
    assign NNin     = nnin_q;

endmodule

// File: tb/tb_nn_input_loader.sv
// -----------------------------------------------------------------------------
// tb_nn_input_loader
// Directed bench for nn_input_loader. A frame-level reference model tracks
// the stored frame, the load/hold phase and the expected handshake/status
// outputs; every cycle the DUT outputs are compared against it. Hand-computed
// literal checks pin the model at the interesting points of each scenario.
// -----------------------------------------------------------------------------
module tb_nn_input_loader;
    import nn_pkg::*;

    logic                              clk = 1'b0;
    logic                              reset;
    logic [PIX_WIDTH-1:0]              pixIn;
    logic                              pixValid;
    logic                              pixLast;
    logic                              pixReady;
    logic                              nnDone;
    logic [NUM_PIXELS*DATA_WIDTH-1:0]  NNin;
    logic                              NNvalid;
    logic                              frameErr;
    logic [9:0]                        pixCount;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;

    // Reference model state
    logic [15:0] m_mem [NUM_PIXELS];
    bit          m_hold, m_ready, m_valid, m_err, m_init;
    int          m_cnt;
    logic [NUM_PIXELS*DATA_WIDTH-1:0] exp_v;

    nn_input_loader dut (
        .clk      (clk),
        .reset    (reset),
        .pixIn    (pixIn),
        .pixValid (pixValid),
        .pixLast  (pixLast),
        .pixReady (pixReady),
        .nnDone   (nnDone),
        .NNin     (NNin),
        .NNvalid  (NNvalid),
        .frameErr (frameErr),
        .pixCount (pixCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] slot(input int i);
        return 16'(NNin >> (i*DATA_WIDTH));
    endfunction

    // Reference model: a frame buffer plus a "presenting" flag.
    always @(posedge clk) begin
        m_init = 1'b1;
        if (!reset) begin
            foreach (m_mem[i]) m_mem[i] = 16'h0000;
            m_hold  = 1'b0;
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else begin
            m_err = 1'b0;
            if (!m_hold) begin
                if (pixValid && m_ready) begin
                    m_mem[m_cnt] = {8'h00, pixIn};
                    if (m_cnt == NUM_PIXELS-1) begin
                        m_hold = 1'b1;
                        m_err  = !pixLast;
                        m_cnt  = 0;
                    end else if (pixLast) begin
                        m_err = 1'b1;
                        m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end else if (nnDone) begin
                m_hold = 1'b0;
            end
            m_ready = !m_hold;
            m_valid = m_hold;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            if (frameErr === 1'b1) err_pulses++;
            chk("pixReady", {31'd0, pixReady}, {31'd0, m_ready});
            chk("NNvalid",  {31'd0, NNvalid},  {31'd0, m_valid});
            chk("frameErr", {31'd0, frameErr}, {31'd0, m_err});
            chk("pixCount", {22'd0, pixCount}, 32'(m_cnt));
            for (int i = 0; i < NUM_PIXELS; i++)
                exp_v[i*DATA_WIDTH +: DATA_WIDTH] = m_mem[i];
            checks++;
            if (NNin !== exp_v) begin
                errors++;
                for (int i = 0; i < NUM_PIXELS; i++) begin
                    if (slot(i) !== m_mem[i]) begin
                        $display("FAIL NNin slot %0d actual=%h expected=%h at %0t",
                                 i, slot(i), m_mem[i], $time);
                        break;
                    end
                end
            end
        end
    end

    // Offer one pixel; returns at the negedge following its accept.
    task automatic send(input logic [7:0] p, input bit last, input int gap);
        int n;
        repeat (gap) begin
            pixValid = 1'b0;
            @(negedge clk);
        end
        pixValid = 1'b1;
        pixIn    = p;
        pixLast  = last;
        n = 0;
        while (pixReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pixReady stayed %b expected 1", pixReady);
        end
        @(negedge clk);
        pixValid = 1'b0;
        pixLast  = 1'b0;
    endtask

    task automatic release_frame();
        nnDone = 1'b1;
        @(negedge clk);
        nnDone = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b0; pixValid = 1'b1; pixIn = 8'h33; pixLast = 1'b0; nnDone = 1'b0;

        // 1. Reset with pixValid asserted
        repeat (2) @(negedge clk);
        chk("rst_NNin_zero", {31'd0, NNin == '0}, 32'd1);
        chk("rst_NNvalid",   {31'd0, NNvalid},    32'd0);
        chk("rst_pixReady",  {31'd0, pixReady},   32'd0);
        chk("rst_pixCount",  {22'd0, pixCount},   32'd0);
        reset = 1'b1; pixValid = 1'b0;
        @(negedge clk);
        chk("rel_pixReady",  {31'd0, pixReady},   32'd1);

        // 2. Full frame i mod 256
        for (int i = 0; i < NUM_PIXELS; i++) send(8'(i), i == NUM_PIXELS-1, 0);
        chk("full_NNvalid",  {31'd0, NNvalid},    32'd1);
        chk("full_slot0",    {16'd0, slot(0)},    32'h0000);
        chk("full_slot255",  {16'd0, slot(255)},  32'h00FF);
        chk("full_slot783",  {16'd0, slot(783)},  32'h000F);
        chk("full_no_err",   32'(err_pulses),     32'd0);
        chk("full_pixCount", {22'd0, pixCount},   32'd0);

        // 3. Hold with pixValid pressure, then release
        pixValid = 1'b1; pixIn = 8'hAA;
        repeat (50) @(negedge clk);
        chk("hold_pixReady", {31'd0, pixReady},   32'd0);
        chk("hold_slot0",    {16'd0, slot(0)},    32'h0000);
        chk("hold_slot255",  {16'd0, slot(255)},  32'h00FF);
        pixValid = 1'b0;
        release_frame();
        chk("rel_NNvalid",   {31'd0, NNvalid},    32'd0);
        chk("rel_pixReady2", {31'd0, pixReady},   32'd1);
        send(8'h42, 1'b0, 0);
        chk("next_slot0",    {16'd0, slot(0)},    32'h0042);
        chk("next_slot1",    {16'd0, slot(1)},    32'h0001);
        chk("next_pixCount", {22'd0, pixCount},   32'd1);

        // 4. Short frame: beat 10 carries pixLast (pixCount == 9)
        for (int i = 1; i <= 9; i++) send(8'(i + 16), i == 9, 0);
        chk("short_err",     {31'd0, frameErr},   32'd1);
        chk("short_count",   {22'd0, pixCount},   32'd0);
        chk("short_valid",   {31'd0, NNvalid},    32'd0);
        chk("short_slot9",   {16'd0, slot(9)},    32'h0019);
        @(negedge clk);
        chk("short_err_end", {31'd0, frameErr},   32'd0);
        for (int i = 0; i < NUM_PIXELS; i++) send(8'(i*7 + 3), i == NUM_PIXELS-1, 0);
        chk("f2_NNvalid",    {31'd0, NNvalid},    32'd1);
        chk("f2_no_err",     {31'd0, frameErr},   32'd0);
        chk("f2_slot0",      {16'd0, slot(0)},    32'h0003);
        chk("f2_slot783",    {16'd0, slot(783)},  32'h006C);
        release_frame();

        // 5. Missing pixLast
        base = err_pulses;
        for (int i = 0; i < NUM_PIXELS; i++) send(8'(i) ^ 8'h5A, 1'b0, 0);
        chk("ovr_err",       {31'd0, frameErr},   32'd1);
        chk("ovr_NNvalid",   {31'd0, NNvalid},    32'd1);
        chk("ovr_slot783",   {16'd0, slot(783)},  32'h0055);
        @(negedge clk);
        chk("ovr_pulses",    32'(err_pulses - base), 32'd1);
        release_frame();

        // 6a. Reset at beat 400
        for (int i = 0; i < 400; i++) send(8'(i + 1), 1'b0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_NNin_zero", {31'd0, NNin == '0}, 32'd1);
        chk("mid_pixCount",  {22'd0, pixCount},   32'd0);
        chk("mid_pixReady",  {31'd0, pixReady},   32'd0);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_PIXELS; i++) send(8'(255 - i), i == NUM_PIXELS-1, 0);
        chk("f3_NNvalid",    {31'd0, NNvalid},    32'd1);
        chk("f3_slot783",    {16'd0, slot(783)},  32'h00F0);

        // 6b. Reset during HOLD
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("hrst_NNvalid",  {31'd0, NNvalid},    32'd0);
        chk("hrst_NNin_zero",{31'd0, NNin == '0}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // 6c. Same frame with random idle gaps
        for (int i = 0; i < NUM_PIXELS; i++)
            send(8'(255 - i), i == NUM_PIXELS-1, ($urandom_range(0, 99) < 30) ? 1 : 0);
        chk("gap_NNvalid",   {31'd0, NNvalid},    32'd1);
        chk("gap_slot0",     {16'd0, slot(0)},    32'h00FF);
        chk("gap_slot400",   {16'd0, slot(400)},  32'h006F);
        chk("gap_slot783",   {16'd0, slot(783)},  32'h00F0);
        release_frame();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
